// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI-style req/gnt/rvalid slave port between NB_REQ masters,
// with an in-order ID FIFO for response routing. Define ARB_LOCK_EN to add per-requester bus locking.
module obi_rr_arbiter #(
    parameter int NB_REQ          = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ-1:0]              we_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0] be_i,
`ifdef ARB_LOCK_EN
    input  logic [NB_REQ-1:0]              lock_i,
`endif
    output logic [NB_REQ-1:0]              gnt_o,
    output logic [NB_REQ-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]          rdata_o,
    output logic                           m_req_o,
    output logic                           m_we_o,
    output logic [ADDR_WIDTH-1:0]          m_addr_o,
    output logic [DATA_WIDTH-1:0]          m_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        m_be_o,
    input  logic                           m_gnt_i,
    input  logic                           m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]          m_rdata_i,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int BEW  = DATA_WIDTH / 8;
    localparam int IDW  = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int FPW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  fifo_q [MAX_OUTSTANDING];
    logic [FPW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            err_q;

    logic [NB_REQ-1:0] eligible;
    logic [IDW-1:0]    win_idx;
    logic [IDW-1:0]    scan;
    logic [IDW-1:0]    head;
    logic              found;
    logic              handshake;
    logic              pop;

`ifdef ARB_LOCK_EN
    logic           locked_q;
    logic [IDW-1:0] lock_id_q;
    logic           win_lock;
`endif

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        return (p == FPW'(MAX_OUTSTANDING - 1)) ? '0 : p + FPW'(1);
    endfunction

    // Mask requests when the ID FIFO is full (registered count) or locked, then scan from rr_ptr.
    always_comb begin
        eligible = req_i;
        if (count_q == CNTW'(MAX_OUTSTANDING)) eligible = '0;
`ifdef ARB_LOCK_EN
        if (locked_q) begin
            for (int k = 0; k < NB_REQ; k++) begin
                if (lock_id_q != IDW'(k)) eligible[k] = 1'b0;
            end
        end
`endif
        if (rst) eligible = '0;

        found   = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (int'(rr_ptr_q) + i >= NB_REQ) scan = IDW'(int'(rr_ptr_q) + i - NB_REQ);
            else                              scan = IDW'(int'(rr_ptr_q) + i);
            if (!found && eligible[scan]) begin
                found   = 1'b1;
                win_idx = scan;
            end
        end

        handshake = found & m_gnt_i;
        pop       = m_rvalid_i && (count_q != '0) && !rst;
        head      = fifo_q[rd_ptr_q];
    end

    always_comb begin
        m_req_o   = found;
        m_we_o    = 1'b0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        m_be_o    = '0;
        gnt_o     = '0;
        rvalid_o  = '0;
`ifdef ARB_LOCK_EN
        win_lock  = 1'b0;
`endif
        for (int k = 0; k < NB_REQ; k++) begin
            if (found && win_idx == IDW'(k)) begin
                m_we_o    = we_i[k];
                m_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                m_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                m_be_o    = be_i[k*BEW +: BEW];
                gnt_o[k]  = m_gnt_i;
`ifdef ARB_LOCK_EN
                win_lock  = lock_i[k];
`endif
            end
            if (pop && head == IDW'(k)) rvalid_o[k] = 1'b1;
        end
    end

    assign rdata_o = m_rdata_i;
    assign busy_o  = (count_q != '0);
    assign err_o   = err_q;

    always_ff @(posedge clk) begin
        if (handshake) fifo_q[wr_ptr_q] <= win_idx;
    end

    // Pointer/count bookkeeping; a push and pop in the same cycle leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
                rr_ptr_q <= (win_idx == IDW'(NB_REQ - 1)) ? '0 : win_idx + IDW'(1);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (handshake && !pop)      count_q <= count_q + CNTW'(1);
            else if (!handshake && pop) count_q <= count_q - CNTW'(1);
            if (m_rvalid_i && count_q == '0) err_q <= 1'b1;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_q  <= 1'b0;
            lock_id_q <= '0;
        end else if (handshake) begin
            locked_q  <= win_lock;
            lock_id_q <= win_idx;
        end
    end
`endif

endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Round-robin arbiter that shares one req/gnt/rvalid memory-slave port (such as a data RAM or peripheral bridge port) between NB_REQ masters, e.g. core LSU, debug unit and SPI-slave loader.
- Tracks up to MAX_OUTSTANDING in-flight transactions in an ID FIFO and routes in-order responses back to the issuing requester.
- Sits between the masters and the slave port inside the core region.

Parameters:
- NB_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; byte enable width is DATA_WIDTH/8
- MAX_OUTSTANDING, 2, ID FIFO depth (1..8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_i  in  NB_REQ  per-requester request
- we_i  in  NB_REQ  write enable
- addr_i  in  NB_REQ*ADDR_WIDTH  flattened addresses; requester k at slice k
- wdata_i  in  NB_REQ*DATA_WIDTH  flattened write data
- be_i  in  NB_REQ*DATA_WIDTH/8  flattened byte enables
- gnt_o  out  NB_REQ  grant, one-hot or zero
- rvalid_o  out  NB_REQ  response valid, one-hot or zero
- rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters
- m_req_o  out  1  slave request
- m_we_o  out  1  slave write enable
- m_addr_o  out  ADDR_WIDTH  slave address
- m_wdata_o  out  DATA_WIDTH  slave write data
- m_be_o  out  DATA_WIDTH/8  slave byte enables
- m_gnt_i  in  1  slave grant
- m_rvalid_i  in  1  slave response valid
- m_rdata_i  in  DATA_WIDTH  slave read data
- busy_o  out  1  at least one transaction outstanding
- err_o  out  1  sticky protocol error

Behaviour:
- Clock/reset: one clock, clk. Reset rst is synchronous and active-high.
- State: rr_ptr (clog2(NB_REQ) bits, min 1), ID FIFO of MAX_OUTSTANDING entries, count (clog2(MAX_OUTSTANDING+1) bits), err flag.
- Reset values: rr_ptr=0, count=0, FIFO pointers=0, err_o=0. While rst=1: m_req_o=0, gnt_o=0, rvalid_o=0.
- Protocol: a requester holds req/we/addr/wdata/be stable until it sees gnt. Responses return in issue order, at least 1 cycle after gnt.
- Arbitration (combinational, zero latency):
  - Eligible = req_i, masked to zero when count==MAX_OUTSTANDING.
  - Winner = first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NB_REQ.
  - m_req_o = any eligible. m_we/addr/wdata/be are muxed from the winner; when no winner they drive 0.
  - gnt_o[winner] = m_gnt_i & m_req_o.
- Handshake (m_req_o & m_gnt_i):
  - Push winner ID into the FIFO.
  - rr_ptr <= (winner+1) mod NB_REQ.
  - rr_ptr is unchanged on cycles without a handshake.
- Response (m_rvalid_i):
  - When count>0: pop the FIFO head and assert rvalid_o[head] the same cycle. rdata_o = m_rdata_i, always passed through.
  - When count==0: no rvalid_o, err_o <= 1. err_o is sticky until rst.
- Simultaneous push and pop: count is unchanged; the FIFO stays consistent.
- Full: the full mask uses the registered count, so a pop in the same cycle does not unblock a grant. The grant resumes the next cycle.
- busy_o = (count != 0), registered-state derived.
- Reset mid-operation: outstanding IDs are discarded. Any later m_rvalid_i sets err_o, so the slave must share the reset.
- Fairness: no requester waits more than NB_REQ-1 handshakes while continuously requesting.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds port lock_i in NB_REQ.
  - A handshake by requester k with lock_i[k]=1 enters LOCKED(k). In LOCKED(k) only requester k is eligible.
  - A handshake by k with lock_i[k]=0 returns to UNLOCKED. rr_ptr then updates as normal.
  - Reset returns to UNLOCKED.
  - Used for atomic read-modify-write sequences.
- Undefined: no lock_i port, pure round-robin, no lock state.

Test Plan:
- All 3 requesters hold req, m_gnt_i=1 every cycle, slave responds 1 cycle later -> gnt_o sequence 001,010,100,001. rvalid_o repeats the same order one cycle later.
- MAX_OUTSTANDING=2, m_rvalid_i held 0, requester 0 issues 3 requests -> 2 grants, then m_req_o=0 and busy_o=1. Pulse m_rvalid_i with m_rdata_i=32'hDEAD_BEEF -> rvalid_o=001, rdata_o=DEADBEEF; the third grant comes on the next cycle.
- count=1 with simultaneous handshake and rvalid -> count stays 1, ID order preserved across 4 back-to-back transfers.
- m_rvalid_i=1 with count=0 -> err_o=1 and stays 1; rvalid_o=0. Asserting rst clears err_o.
- rst asserted with 2 outstanding -> next cycle busy_o=0, rr_ptr=0. A request from requester 2 alone is granted at once.
- ARB_LOCK_EN: requester 1 issues with lock_i=2'b10 while requesters 0 and 2 request -> only requester 1 is granted until its unlocked handshake. Requester 2 is granted next.
